// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_t       : arbiter FSM states
//   REQ_M / REQ_L : requester ids (pipeline / loader)
//   DEPTH_DEFAULT : default data-memory depth in 64-bit words
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR,
    RESP
  } state_t;

  localparam logic REQ_M = 1'b0;
  localparam logic REQ_L = 1'b1;

  localparam int unsigned DEPTH_DEFAULT = 1024;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
//   req/we/addr/wdata : request, held by the requester until ack
//   rdata/ack/err     : response; ack is a one-cycle pulse, err qualifies ack,
//                       rdata holds until the next ack on this port
// modport master : requester side (pipeline memory stage or loader)
// modport slave  : arbiter side
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);

endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline memory stage
// (port m, i.e. m_req/m_we/m_addr/m_wdata -> m_rdata/m_ack/m_err) and the
// program loader (port l, same signal set). Performs the 64-bit bounds check,
// sequences each access over LAT memory cycles and raises m_stall while a
// pipeline access is outstanding.
//   clk, rst_n          : clock, synchronous active-low reset
//   m, l                : requester ports (dmem_arbiter_if.slave)
//   m_stall             : m_req && !m_ack, freezes the M/W registers
//   mem_en/mem_we       : memory enable / write strobe (write in first cycle)
//   mem_addr/mem_wdata  : memory word address / write data
//   mem_rdata           : memory read data, valid at end of the LAT-th cycle
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEFAULT,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave m,
  dmem_arbiter_if.slave l,
  output logic          m_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [SW-1:0] starve_cnt;
  logic          win;
  logic          lat_we;

  logic          grant_l;
  logic          g_we;
  logic [63:0]   g_addr;
  logic [63:0]   g_wdata;

  // The loader only beats a concurrent pipeline request once it has lost
  // STARVE_MAX arbitrations in a row.
  always_comb begin
    grant_l = l.req && (!m.req || starve_cnt == SW'(STARVE_MAX));
    g_we    = grant_l ? l.we    : m.we;
    g_addr  = grant_l ? l.addr  : m.addr;
    g_wdata = grant_l ? l.wdata : m.wdata;
  end

  always_comb m_stall = m.req && !m.ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      win        <= REQ_M;
      lat_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m.rdata    <= '0;
      m.ack      <= 1'b0;
      m.err      <= 1'b0;
      l.rdata    <= '0;
      l.ack      <= 1'b0;
      l.err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m.req || l.req) begin
            win    <= grant_l;
            lat_we <= g_we;
            if (grant_l)
              starve_cnt <= '0;
            else if (l.req)
              starve_cnt <= starve_cnt + SW'(1);
            // Address and write data are latched in mem_addr/mem_wdata, so
            // later changes on the request port have no effect.
            if (g_addr >= 64'(DEPTH)) begin
              state <= ERR;
              if (grant_l) begin
                l.ack   <= 1'b1;
                l.err   <= 1'b1;
                l.rdata <= '0;
              end else begin
                m.ack   <= 1'b1;
                m.err   <= 1'b1;
                m.rdata <= '0;
              end
            end else begin
              state     <= BUSY;
              cnt       <= 4'd1;
              mem_en    <= 1'b1;
              mem_we    <= g_we;
              mem_addr  <= g_addr[AW-1:0];
              mem_wdata <= g_wdata;
            end
          end
        end
        BUSY: begin
          mem_we <= 1'b0;
          if (cnt == 4'(LAT)) begin
            mem_en <= 1'b0;
            state  <= RESP;
            if (win == REQ_L) begin
              l.ack   <= 1'b1;
              l.rdata <= lat_we ? '0 : mem_rdata;
            end else begin
              m.ack   <= 1'b1;
              m.rdata <= lat_we ? '0 : mem_rdata;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ERR, RESP: begin
          m.ack <= 1'b0;
          m.err <= 1'b0;
          l.ack <= 1'b0;
          l.err <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (LAT=2, STARVE_MAX=4) with a one-cycle
// behavioural memory model.
module tb_dmem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_stall;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter_if m_if ();
  dmem_arbiter_if l_if ();

  dmem_arbiter #(
    .DEPTH(1024),
    .AW(10),
    .LAT(LAT),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m(m_if),
    .l(l_if),
    .m_stall(m_stall),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // memory model and activity counters (monotonic; bench takes differences)
  logic [63:0] mem [0:1023];
  int we_pulses = 0;
  int en_cycles = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
      en_cycles <= en_cycles + 1;
    end
    if (mem_we) we_pulses <= we_pulses + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction on the selected port; returns cycles from request to
  // ack, cycles with m_stall high, the response and whether the other port acked.
  task automatic run_txn(input bit lsel, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata, output int cycles, output int stall_cyc,
                         output logic [63:0] rdata, output logic err, output logic other_ack);
    if (lsel) begin
      l_if.req = 1'b1; l_if.we = we; l_if.addr = addr; l_if.wdata = wdata;
    end else begin
      m_if.req = 1'b1; m_if.we = we; m_if.addr = addr; m_if.wdata = wdata;
    end
    #1;
    cycles = 0;
    stall_cyc = 0;
    other_ack = 1'b0;
    while (!(lsel ? l_if.ack : m_if.ack) && cycles < 40) begin
      if (m_stall) stall_cyc++;
      tick();
      cycles++;
      if (lsel ? m_if.ack : l_if.ack) other_ack = 1'b1;
    end
    rdata = lsel ? l_if.rdata : m_if.rdata;
    err   = lsel ? l_if.err : m_if.err;
    m_if.req = 1'b0;
    l_if.req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, stl, en0, we0, k, l_k, m_k, nack;
    logic [63:0] rd;
    logic        er, oth, early_m;
    logic [4:0]  order;

    m_if.req = 0; m_if.we = 0; m_if.addr = '0; m_if.wdata = '0;
    l_if.req = 0; l_if.we = 0; l_if.addr = '0; l_if.wdata = '0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_m_ack",   m_if.ack,   0);
    check("rst_m_err",   m_if.err,   0);
    check("rst_m_rdata", m_if.rdata, 0);
    check("rst_l_ack",   l_if.ack,   0);
    check("rst_mem_en",  mem_en,     0);
    check("rst_mem_we",  mem_we,     0);
    check("rst_stall",   m_stall,    0);
    rst_n = 1'b1;
    tick();

    // pipeline write then read of address 5
    en0 = en_cycles; we0 = we_pulses;
    run_txn(0, 1, 64'd5, 64'h2A, cyc, stl, rd, er, oth);
    check("wr5_latency",  cyc, 3);
    check("wr5_err",      er, 0);
    check("wr5_rdata",    rd, 0);
    check("wr5_we_pulse", we_pulses - we0, 1);
    check("wr5_en_cyc",   en_cycles - en0, LAT);
    check("wr5_l_ack",    oth, 0);
    check("wr5_stall",    stl, 3);
    run_txn(0, 0, 64'd5, 64'h0, cyc, stl, rd, er, oth);
    check("rd5_latency",  cyc, 3);
    check("rd5_rdata",    rd, 64'h2A);
    check("rd5_err",      er, 0);

    // out-of-range at exactly DEPTH
    en0 = en_cycles;
    run_txn(0, 0, 64'd1024, 64'h0, cyc, stl, rd, er, oth);
    check("oor1024_latency", cyc, 1);
    check("oor1024_err",     er, 1);
    check("oor1024_rdata",   rd, 0);
    check("oor1024_mem_en",  en_cycles - en0, 0);
    check("oor1024_stall",   stl, 1);
    check("oor1024_err_clr", m_if.err, 0);

    // both requesters held: four pipeline grants then the loader
    m_if.req = 1; m_if.we = 1; m_if.addr = 64'd10; m_if.wdata = 64'h1;
    l_if.req = 1; l_if.we = 1; l_if.addr = 64'd11; l_if.wdata = 64'h2;
    order = '0; nack = 0; k = 0;
    while (nack < 5 && k < 100) begin
      tick(); k++;
      if (m_if.ack || l_if.ack) begin
        order[nack] = l_if.ack;
        nack++;
        if (nack == 4) check("starve_cnt_at4", 64'(dut.starve_cnt), 4);
      end
    end
    m_if.req = 0; l_if.req = 0;
    check("starve_nack",  nack, 5);
    check("starve_order", order, 5'b10000);
    check("starve_clear", 64'(dut.starve_cnt), 0);
    tick();

    // loader write to 7, pipeline read of 7 raised one cycle later
    l_if.req = 1; l_if.we = 1; l_if.addr = 64'd7; l_if.wdata = 64'hBEEF;
    tick();
    m_if.req = 1; m_if.we = 0; m_if.addr = 64'd7; m_if.wdata = '0;
    #1;
    k = 1; l_k = -1; m_k = -1; stl = 0; early_m = 0;
    while (m_k < 0 && k < 40) begin
      if (m_stall) stl++;
      tick(); k++;
      if (l_if.ack) begin
        l_k = k;
        if (m_if.ack) early_m = 1;
        check("ld7_l_rdata", l_if.rdata, 0);
        check("ld7_l_err",   l_if.err, 0);
        l_if.req = 0;
      end
      if (m_if.ack) m_k = k;
    end
    m_if.req = 0;
    check("ld7_l_ack_cycle", l_k, 3);
    check("ld7_m_ack_cycle", m_k, 7);
    check("ld7_stall_cyc",   stl, 6);
    check("ld7_no_m_ack",    early_m, 0);
    check("ld7_m_rdata",     m_if.rdata, 64'hBEEF);
    tick();

    // reset during the second BUSY cycle
    m_if.req = 1; m_if.we = 0; m_if.addr = 64'd5;
    tick(); tick();
    check("rstmid_mem_en", mem_en, 1);
    rst_n = 0; m_if.req = 0;
    tick();
    check("rstmid_m_ack",   m_if.ack, 0);
    check("rstmid_l_ack",   l_if.ack, 0);
    check("rstmid_mem_en",  mem_en, 0);
    check("rstmid_m_rdata", m_if.rdata, 0);
    check("rstmid_l_rdata", l_if.rdata, 0);
    rst_n = 1;
    tick();
    check("rstmid_no_ack", m_if.ack, 0);
    run_txn(0, 0, 64'd5, 64'h0, cyc, stl, rd, er, oth);
    check("rstmid_fresh_lat",   cyc, 3);
    check("rstmid_fresh_rdata", rd, 64'h2A);

    // 64-bit bounds: all-ones is out of range, 1023 is the last valid word
    en0 = en_cycles;
    run_txn(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, cyc, stl, rd, er, oth);
    check("oorff_latency", cyc, 1);
    check("oorff_err",     er, 1);
    check("oorff_rdata",   rd, 0);
    check("oorff_mem_en",  en_cycles - en0, 0);
    run_txn(0, 1, 64'd1023, 64'h1234_5678_9ABC_DEF0, cyc, stl, rd, er, oth);
    check("wr1023_latency", cyc, 3);
    check("wr1023_err",     er, 0);
    run_txn(0, 0, 64'd1023, 64'h0, cyc, stl, rd, er, oth);
    check("rd1023_rdata",   rd, 64'h1234_5678_9ABC_DEF0);

    // loader error leaves the pipeline port untouched
    run_txn(1, 0, 64'd1024, 64'h0, cyc, stl, rd, er, oth);
    check("l_oor_latency", cyc, 1);
    check("l_oor_err",     er, 1);
    check("l_oor_m_ack",   oth, 0);
    check("l_oor_stall",   stl, 0);
    check("l_oor_m_rdata", m_if.rdata, 64'h1234_5678_9ABC_DEF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
